// File: rtl/minmax_pkg.sv
// Shared types and constants for the 4-bit streaming min/max tracker.
package minmax_pkg;

  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] MAX_INIT = 4'h0;
  localparam logic [DATA_W-1:0] MIN_INIT = 4'hF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FULL  = 2'd2
  } state_e;

  // One-hot {lt, eq, gt} pattern as produced by compare_4bit.
  typedef enum logic [2:0] {
    CMP_LT = 3'b100,
    CMP_EQ = 3'b010,
    CMP_GT = 3'b001
  } cmp_e;

endpackage

// File: rtl/compare_4bit.sv
// Unsigned magnitude comparator: flags a_i relative to b_i.
module compare_4bit
  import minmax_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              lt_o,
  output logic              eq_o,
  output logic              gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/minmax_tracker_4bit.sv
// Streaming min/max tracker for 4-bit unsigned samples with a saturating count.
// Optional MINMAX_RANGE_EN adds a registered range_out = max_out - min_out.
module minmax_tracker_4bit
  import minmax_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic              new_max,
  output logic              new_min,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              cnt_sat
`ifdef MINMAX_RANGE_EN
  ,
  output logic [DATA_W-1:0] range_out
`endif
);

  state_e              state_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   max_q, min_q;
  logic                new_max_q, new_min_q;
  logic [CNT_W-1:0]    sample_cnt_q;
  logic                cnt_sat_q;

  logic [DATA_W-1:0]   max_d, min_d;
  logic                new_max_d, new_min_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                hit_sat;
  logic                accept;

  logic                max_lt, max_eq, max_gt;
  logic                min_lt, min_eq, min_gt;

  compare_4bit u_cmp_max (
    .a_i  (in_data),
    .b_i  (max_q),
    .lt_o (max_lt),
    .eq_o (max_eq),
    .gt_o (max_gt)
  );

  compare_4bit u_cmp_min (
    .a_i  (in_data),
    .b_i  (min_q),
    .lt_o (min_lt),
    .eq_o (min_eq),
    .gt_o (min_gt)
  );

  assign in_ready = (state_q != FULL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    max_d     = max_q;
    min_d     = min_q;
    new_max_d = 1'b0;
    new_min_d = 1'b0;
    cnt_d     = sample_cnt_q + CNT_W'(1);
    if (state_q == EMPTY) begin
      max_d     = in_data;
      min_d     = in_data;
      new_max_d = 1'b1;
      new_min_d = 1'b1;
    end else begin
      if ({max_lt, max_eq, max_gt} == CMP_GT) begin
        max_d     = in_data;
        new_max_d = 1'b1;
      end
      if ({min_lt, min_eq, min_gt} == CMP_LT) begin
        min_d     = in_data;
        new_min_d = 1'b1;
      end
    end
  end

  // Saturation is judged on the post-accept count, so CNT_W==1 goes straight to FULL.
  assign hit_sat = &cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      max_q        <= MAX_INIT;
      min_q        <= MIN_INIT;
      new_max_q    <= 1'b0;
      new_min_q    <= 1'b0;
      sample_cnt_q <= '0;
      cnt_sat_q    <= 1'b0;
    end else begin
      new_max_q <= 1'b0;
      new_min_q <= 1'b0;
      if (accept) begin
        state_q      <= hit_sat ? FULL : TRACK;
        out_valid_q  <= 1'b1;
        max_q        <= max_d;
        min_q        <= min_d;
        new_max_q    <= new_max_d;
        new_min_q    <= new_min_d;
        sample_cnt_q <= cnt_d;
        cnt_sat_q    <= hit_sat;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign max_out    = max_q;
  assign min_out    = min_q;
  assign new_max    = new_max_q;
  assign new_min    = new_min_q;
  assign sample_cnt = sample_cnt_q;
  assign cnt_sat    = cnt_sat_q;

`ifdef MINMAX_RANGE_EN
  logic [DATA_W-1:0] range_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      range_q <= '0;
    end else if (accept) begin
      range_q <= max_d - min_d;
    end
  end

  assign range_out = range_q;
`endif

endmodule
